// File: rtl/issuer_pkg.sv
// rtl/issuer_pkg.sv - shared state encoding, opcodes and width helper for cmd_issuer_rr
package issuer_pkg;

  localparam logic INSTR_LD   = 1'b0;
  localparam logic INSTR_INFO = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_STALL,
    ST_WRITEBACK,
    ST_LD0,
    ST_LD1,
    ST_INFO
  } state_t;

  // Instruction = {id, opcode bit, payload}; payload is sized to hold {count, op, wr_addr}.
  function automatic int instr_width(input int id_w, input int count_w,
                                     input int op_w, input int addr_w);
    return id_w + 1 + count_w + op_w + addr_w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin first-set-bit search starting after the pointer, with wrap
module rr_pick #(
  parameter int N    = 4,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [IDXW-1:0] i_ptr,
  output logic [IDXW-1:0] o_idx,
  output logic            o_found
);

  logic [IDXW-1:0] cand;

  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IDXW'((int'(i_ptr) + i) % N);
      if (!o_found && i_req[cand]) begin
        o_found = 1'b1;
        o_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/cmd_issuer_rr.sv
// rtl/cmd_issuer_rr.sv - dependency-checked command issuer dispatching LD/LD/INFO triplets
// round-robin across SIMD processors, with concurrent finish retirement.
module cmd_issuer_rr
  import issuer_pkg::*;
#(
  parameter int PROC_COUNT = 4,
  parameter int ID_W       = 8,
  parameter int ADDR_W     = 16,
  parameter int OP_W       = 4,
  parameter int COUNT_W    = 8,
  parameter int RETRY_W    = 2,
  parameter int MAX_RETRY  = 3
) (
  input  logic                                                 i_clk,
  input  logic                                                 i_rst,
  input  logic                                                 i_cmd_valid,
  output logic                                                 o_cmd_ready,
  input  logic [ID_W-1:0]                                      i_cmd_id,
  input  logic [ID_W-1:0]                                      i_cmd_dep,
  input  logic                                                 i_cmd_dep_valid,
  input  logic [ADDR_W-1:0]                                    i_cmd_addr0,
  input  logic [ADDR_W-1:0]                                    i_cmd_addr1,
  input  logic [ADDR_W-1:0]                                    i_cmd_wr_addr,
  input  logic [OP_W-1:0]                                      i_cmd_op,
  input  logic [COUNT_W-1:0]                                   i_cmd_count,
  input  logic [RETRY_W-1:0]                                   i_cmd_retry,
  output logic                                                 o_wb_valid,
  input  logic                                                 i_wb_ready,
  output logic [2*ID_W+3*ADDR_W+OP_W+COUNT_W+RETRY_W:0]        o_wb_cmd,
  input  logic [PROC_COUNT-1:0]                                i_busy,
  output logic [PROC_COUNT-1:0]                                o_instr_valid,
  input  logic [PROC_COUNT-1:0]                                i_instr_ready,
  output logic [instr_width(ID_W, COUNT_W, OP_W, ADDR_W)-1:0]  o_instr,
  input  logic [PROC_COUNT-1:0]                                i_finish,
  output logic [PROC_COUNT-1:0]                                o_finish_ack,
  output logic [$clog2(PROC_COUNT+1)-1:0]                      o_inflight,
  output logic                                                 o_err
);

  localparam int PIDX_W  = $clog2(PROC_COUNT);
  localparam int INF_W   = $clog2(PROC_COUNT + 1);
  localparam int PAY_W   = COUNT_W + OP_W + ADDR_W;
  localparam int INSTR_W = instr_width(ID_W, COUNT_W, OP_W, ADDR_W);
  localparam int WB_W    = 2*ID_W + 1 + 3*ADDR_W + OP_W + COUNT_W + RETRY_W;

  state_t                         state_q, state_d;
  logic [ID_W-1:0]                id_q, id_d, dep_q, dep_d;
  logic                           dep_valid_q, dep_valid_d;
  logic [ADDR_W-1:0]              addr0_q, addr0_d, addr1_q, addr1_d, wr_addr_q, wr_addr_d;
  logic [OP_W-1:0]                op_q, op_d;
  logic [COUNT_W-1:0]             count_q, count_d;
  logic [RETRY_W-1:0]             retry_q, retry_d;
  logic [PIDX_W-1:0]              sel_q, sel_d, rr_ptr_q, rr_ptr_d;
  logic [PROC_COUNT-1:0]          sb_valid_q, sb_valid_d;
  logic [PROC_COUNT-1:0][ID_W-1:0] sb_id_q, sb_id_d;
  logic                           cmd_ready_q, cmd_ready_d;
  logic                           wb_valid_q, wb_valid_d;
  logic [WB_W-1:0]                wb_cmd_q, wb_cmd_d;
  logic [PROC_COUNT-1:0]          instr_valid_q, instr_valid_d;
  logic [INSTR_W-1:0]             instr_q, instr_d;
  logic [PROC_COUNT-1:0]          finish_ack_q, finish_ack_d;
  logic                           err_q, err_d;

  logic [PROC_COUNT-1:0] free;
  logic [PROC_COUNT-1:0] fin_eff;
  logic [PIDX_W-1:0]     pick_idx, fin_idx;
  logic                  pick_found, fin_hit, hit, in_dispatch;
  logic [INF_W-1:0]      inflight;

  assign free        = ~sb_valid_q & ~i_busy;
  // A finish still asserted during its own ack cycle must not be served twice.
  assign fin_eff     = i_finish & ~finish_ack_q;
  assign in_dispatch = (state_q == ST_LD0) || (state_q == ST_LD1) || (state_q == ST_INFO);

  rr_pick #(
    .N    (PROC_COUNT),
    .IDXW (PIDX_W)
  ) u_rr_pick (
    .i_req   (free),
    .i_ptr   (rr_ptr_q),
    .o_idx   (pick_idx),
    .o_found (pick_found)
  );

  always_comb begin
    hit      = 1'b0;
    inflight = '0;
    fin_hit  = 1'b0;
    fin_idx  = '0;
    for (int k = 0; k < PROC_COUNT; k++) begin
      if (sb_valid_q[k] && (sb_id_q[k] == dep_q)) hit = 1'b1;
      if (sb_valid_q[k]) inflight = inflight + INF_W'(1);
    end
    hit = hit & dep_valid_q;
    for (int k = PROC_COUNT - 1; k >= 0; k--) begin
      if (fin_eff[k]) begin
        fin_hit = 1'b1;
        fin_idx = PIDX_W'(k);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    dep_d         = dep_q;
    dep_valid_d   = dep_valid_q;
    addr0_d       = addr0_q;
    addr1_d       = addr1_q;
    wr_addr_d     = wr_addr_q;
    op_d          = op_q;
    count_d       = count_q;
    retry_d       = retry_q;
    sel_d         = sel_q;
    rr_ptr_d      = rr_ptr_q;
    sb_valid_d    = sb_valid_q;
    sb_id_d       = sb_id_q;
    cmd_ready_d   = 1'b0;
    wb_valid_d    = wb_valid_q;
    wb_cmd_d      = wb_cmd_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    finish_ack_d  = '0;
    err_d         = err_q;

    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid && (|free)) begin
          cmd_ready_d = 1'b1;
          id_d        = i_cmd_id;
          dep_d       = i_cmd_dep;
          dep_valid_d = i_cmd_dep_valid;
          addr0_d     = i_cmd_addr0;
          addr1_d     = i_cmd_addr1;
          wr_addr_d   = i_cmd_wr_addr;
          op_d        = i_cmd_op;
          count_d     = i_cmd_count;
          retry_d     = i_cmd_retry;
          state_d     = ST_CHECK;
        end
      end
      ST_CHECK, ST_STALL: begin
        if (hit) begin
          if (state_q == ST_CHECK) begin
            if (retry_q < RETRY_W'(MAX_RETRY)) begin
              wb_valid_d = 1'b1;
              wb_cmd_d   = {id_q, dep_q, dep_valid_q, addr0_q, addr1_q, wr_addr_q,
                            op_q, count_q, retry_q + RETRY_W'(1)};
              state_d    = ST_WRITEBACK;
            end else begin
              state_d = ST_STALL;
            end
          end
        end else if (pick_found) begin
          sel_d                = pick_idx;
          rr_ptr_d             = pick_idx;
          sb_valid_d[pick_idx] = 1'b1;
          sb_id_d[pick_idx]    = id_q;
          instr_valid_d        = PROC_COUNT'(1) << pick_idx;
          instr_d              = {id_q, INSTR_LD, PAY_W'(addr0_q)};
          state_d              = ST_LD0;
        end
      end
      ST_WRITEBACK: begin
        if (i_wb_ready) begin
          wb_valid_d = 1'b0;
          wb_cmd_d   = '0;
          state_d    = ST_IDLE;
        end
      end
      ST_LD0: begin
        if (i_instr_ready[sel_q]) begin
          instr_d = {id_q, INSTR_LD, PAY_W'(addr1_q)};
          state_d = ST_LD1;
        end
      end
      ST_LD1: begin
        if (i_instr_ready[sel_q]) begin
          instr_d = {id_q, INSTR_INFO, count_q, op_q, wr_addr_q};
          state_d = ST_INFO;
        end
      end
      ST_INFO: begin
        if (i_instr_ready[sel_q]) begin
          instr_valid_d = '0;
          instr_d       = '0;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Allocation only targets invalid entries and retire only clears valid ones, so they never collide.
    if (fin_hit) begin
      finish_ack_d[fin_idx] = 1'b1;
      if (!sb_valid_q[fin_idx]) begin
        err_d = 1'b1;
      end else begin
        sb_valid_d[fin_idx] = 1'b0;
        if (in_dispatch && (sel_q == fin_idx)) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      id_q          <= '0;
      dep_q         <= '0;
      dep_valid_q   <= 1'b0;
      addr0_q       <= '0;
      addr1_q       <= '0;
      wr_addr_q     <= '0;
      op_q          <= '0;
      count_q       <= '0;
      retry_q       <= '0;
      sel_q         <= '0;
      rr_ptr_q      <= PIDX_W'(PROC_COUNT - 1);
      sb_valid_q    <= '0;
      sb_id_q       <= '0;
      cmd_ready_q   <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_cmd_q      <= '0;
      instr_valid_q <= '0;
      instr_q       <= '0;
      finish_ack_q  <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      id_q          <= id_d;
      dep_q         <= dep_d;
      dep_valid_q   <= dep_valid_d;
      addr0_q       <= addr0_d;
      addr1_q       <= addr1_d;
      wr_addr_q     <= wr_addr_d;
      op_q          <= op_d;
      count_q       <= count_d;
      retry_q       <= retry_d;
      sel_q         <= sel_d;
      rr_ptr_q      <= rr_ptr_d;
      sb_valid_q    <= sb_valid_d;
      sb_id_q       <= sb_id_d;
      cmd_ready_q   <= cmd_ready_d;
      wb_valid_q    <= wb_valid_d;
      wb_cmd_q      <= wb_cmd_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      finish_ack_q  <= finish_ack_d;
      err_q         <= err_d;
    end
  end

  assign o_cmd_ready   = cmd_ready_q;
  assign o_wb_valid    = wb_valid_q;
  assign o_wb_cmd      = wb_cmd_q;
  assign o_instr_valid = instr_valid_q;
  assign o_instr       = instr_q;
  assign o_finish_ack  = finish_ack_q;
  assign o_inflight    = inflight;
  assign o_err         = err_q;

endmodule

// File: tb/tb_cmd_issuer_rr.sv
// tb/tb_cmd_issuer_rr.sv - directed self-checking bench for cmd_issuer_rr
module tb_cmd_issuer_rr;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [7:0]  i_cmd_id, i_cmd_dep;
  logic        i_cmd_dep_valid;
  logic [15:0] i_cmd_addr0, i_cmd_addr1, i_cmd_wr_addr;
  logic [3:0]  i_cmd_op;
  logic [7:0]  i_cmd_count;
  logic [1:0]  i_cmd_retry;
  logic        o_wb_valid;
  logic        i_wb_ready;
  logic [78:0] o_wb_cmd;
  logic [3:0]  i_busy;
  logic [3:0]  o_instr_valid;
  logic [3:0]  i_instr_ready;
  logic [36:0] o_instr;
  logic [3:0]  i_finish;
  logic [3:0]  o_finish_ack;
  logic [2:0]  o_inflight;
  logic        o_err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  cmd_issuer_rr dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_cmd_valid     (i_cmd_valid),
    .o_cmd_ready     (o_cmd_ready),
    .i_cmd_id        (i_cmd_id),
    .i_cmd_dep       (i_cmd_dep),
    .i_cmd_dep_valid (i_cmd_dep_valid),
    .i_cmd_addr0     (i_cmd_addr0),
    .i_cmd_addr1     (i_cmd_addr1),
    .i_cmd_wr_addr   (i_cmd_wr_addr),
    .i_cmd_op        (i_cmd_op),
    .i_cmd_count     (i_cmd_count),
    .i_cmd_retry     (i_cmd_retry),
    .o_wb_valid      (o_wb_valid),
    .i_wb_ready      (i_wb_ready),
    .o_wb_cmd        (o_wb_cmd),
    .i_busy          (i_busy),
    .o_instr_valid   (o_instr_valid),
    .i_instr_ready   (i_instr_ready),
    .o_instr         (o_instr),
    .i_finish        (i_finish),
    .o_finish_ack    (o_finish_ack),
    .o_inflight      (o_inflight),
    .o_err           (o_err)
  );

  task automatic expect_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [36:0] ld_instr(input logic [7:0] id, input logic [15:0] a);
    return {id, 1'b0, 12'h000, a};
  endfunction

  function automatic logic [36:0] info_instr(input logic [7:0] id, input logic [7:0] cnt,
                                             input logic [3:0] op, input logic [15:0] wr);
    return {id, 1'b1, cnt, op, wr};
  endfunction

  task automatic do_reset();
    i_rst         = 1'b1;
    i_cmd_valid   = 1'b0;
    i_finish      = 4'h0;
    i_wb_ready    = 1'b0;
    i_busy        = 4'h0;
    i_instr_ready = 4'hF;
    repeat (2) tick();
    i_rst = 1'b0;
  endtask

  // Command fields follow a fixed pattern derived from the id.
  task automatic issue(input logic [7:0] id, input logic [7:0] dep, input logic dv, input logic [1:0] rt);
    i_cmd_id        = id;
    i_cmd_dep       = dep;
    i_cmd_dep_valid = dv;
    i_cmd_retry     = rt;
    i_cmd_addr0     = {8'hA0, id};
    i_cmd_addr1     = {8'hB0, id};
    i_cmd_wr_addr   = {8'hC0, id};
    i_cmd_op        = id[3:0];
    i_cmd_count     = id + 8'd1;
    i_cmd_valid     = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_cmd_ready) break;
    end
    expect_eq("pop", o_cmd_ready, 1'b1);
    i_cmd_valid = 1'b0;
  endtask

  task automatic expect_dispatch(input int proc, input logic [7:0] id);
    for (int i = 0; i < 10; i++) begin
      if (o_instr_valid != 4'h0) break;
      tick();
    end
    expect_eq("ld0_valid", o_instr_valid, 4'b0001 << proc);
    expect_eq("ld0_instr", o_instr, ld_instr(id, {8'hA0, id}));
    tick();
    expect_eq("ld1_valid", o_instr_valid, 4'b0001 << proc);
    expect_eq("ld1_instr", o_instr, ld_instr(id, {8'hB0, id}));
    tick();
    expect_eq("info_valid", o_instr_valid, 4'b0001 << proc);
    expect_eq("info_instr", o_instr, info_instr(id, id + 8'd1, id[3:0], {8'hC0, id}));
    tick();
    expect_eq("dispatch_done", o_instr_valid, 4'h0);
  endtask

  task automatic finish_one(input int proc);
    i_finish = 4'b0001 << proc;
    tick();
    expect_eq("fin_ack", o_finish_ack, 4'b0001 << proc);
    i_finish = 4'h0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_id = '0; i_cmd_dep = '0; i_cmd_dep_valid = 1'b0;
    i_cmd_addr0 = '0; i_cmd_addr1 = '0; i_cmd_wr_addr = '0; i_cmd_op = '0; i_cmd_count = '0;
    i_cmd_retry = '0; i_wb_ready = 1'b0; i_busy = '0; i_instr_ready = 4'hF; i_finish = '0;

    do_reset();
    expect_eq("rst_cmd_ready", o_cmd_ready, 1'b0);
    expect_eq("rst_wb", {o_wb_valid, o_wb_cmd}, 80'h0);
    expect_eq("rst_instr", {o_instr_valid, o_instr}, 41'h0);
    expect_eq("rst_ack", o_finish_ack, 4'h0);
    expect_eq("rst_inflight", o_inflight, 3'd0);
    expect_eq("rst_err", o_err, 1'b0);

    // Single command, processor 0 holds off LD0 for two cycles.
    i_instr_ready = 4'h0;
    issue(8'd5, 8'd0, 1'b0, 2'd0);
    tick();
    expect_eq("t1_ld0_valid", o_instr_valid, 4'b0001);
    expect_eq("t1_ld0_instr", o_instr, ld_instr(8'd5, 16'hA005));
    tick();
    expect_eq("t1_ld0_hold_valid", o_instr_valid, 4'b0001);
    expect_eq("t1_ld0_hold_instr", o_instr, ld_instr(8'd5, 16'hA005));
    i_instr_ready = 4'hF;
    tick();
    expect_eq("t1_ld1_instr", o_instr, ld_instr(8'd5, 16'hB005));
    tick();
    expect_eq("t1_info_instr", o_instr, info_instr(8'd5, 8'd6, 4'd5, 16'hC005));
    tick();
    expect_eq("t1_done", o_instr_valid, 4'h0);
    expect_eq("t1_inflight", o_inflight, 3'd1);

    // Four independent commands rotate over all processors.
    do_reset();
    for (int p = 0; p < 4; p++) begin
      issue(8'd10 + 8'(p), 8'd0, 1'b0, 2'd0);
      expect_dispatch(p, 8'd10 + 8'(p));
    end
    expect_eq("t2_inflight4", o_inflight, 3'd4);
    finish_one(1);
    expect_eq("t2_inflight3", o_inflight, 3'd3);
    issue(8'd14, 8'd0, 1'b0, 2'd0);
    expect_dispatch(1, 8'd14);
    expect_eq("t2_inflight4b", o_inflight, 3'd4);

    // Two finishes together are acked lowest first on consecutive cycles.
    i_finish = 4'b0110;
    tick();
    expect_eq("dbl_ack_a", o_finish_ack, 4'b0010);
    expect_eq("dbl_inflight_a", o_inflight, 3'd3);
    i_finish = 4'b0100;
    tick();
    expect_eq("dbl_ack_b", o_finish_ack, 4'b0100);
    i_finish = 4'b0000;
    tick();
    expect_eq("dbl_ack_done", o_finish_ack, 4'h0);
    expect_eq("dbl_inflight", o_inflight, 3'd2);
    finish_one(0);
    finish_one(3);
    expect_eq("t2_empty", o_inflight, 3'd0);

    // Dependency on id 9 held by proc 2: writeback, then stall.
    issue(8'd9, 8'd0, 1'b0, 2'd0);
    expect_dispatch(2, 8'd9);
    issue(8'd20, 8'd9, 1'b1, 2'd0);
    tick();
    expect_eq("wb_valid", o_wb_valid, 1'b1);
    expect_eq("wb_cmd", o_wb_cmd,
              {8'd20, 8'd9, 1'b1, 16'hA014, 16'hB014, 16'hC014, 4'h4, 8'h15, 2'd1});
    expect_eq("wb_no_instr", o_instr_valid, 4'h0);
    tick();
    expect_eq("wb_hold", o_wb_valid, 1'b1);
    i_wb_ready = 1'b1;
    tick();
    expect_eq("wb_done", o_wb_valid, 1'b0);
    i_wb_ready = 1'b0;

    issue(8'd21, 8'd9, 1'b1, 2'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_eq("stall_no_wb", o_wb_valid, 1'b0);
      expect_eq("stall_no_instr", o_instr_valid, 4'h0);
    end
    expect_eq("stall_no_pop", o_cmd_ready, 1'b0);
    i_finish = 4'b0100;
    tick();
    expect_eq("stall_ack", o_finish_ack, 4'b0100);
    i_finish = 4'h0;
    tick();
    expect_eq("stall_release", o_instr_valid, 4'b1000);
    expect_dispatch(3, 8'd21);
    expect_eq("t3_err", o_err, 1'b0);

    // Retire on proc 0 in the same cycle as allocation to proc 3.
    do_reset();
    for (int p = 0; p < 3; p++) begin
      issue(8'd30 + 8'(p), 8'd0, 1'b0, 2'd0);
      expect_dispatch(p, 8'd30 + 8'(p));
    end
    issue(8'd33, 8'd0, 1'b0, 2'd0);
    i_finish = 4'b0001;
    tick();
    expect_eq("same_cyc_ack", o_finish_ack, 4'b0001);
    expect_eq("same_cyc_alloc", o_instr_valid, 4'b1000);
    expect_eq("same_cyc_inflight", o_inflight, 3'd3);
    i_finish = 4'h0;
    expect_dispatch(3, 8'd33);
    expect_eq("t4_err", o_err, 1'b0);

    // Reset pulsed while LD1 is being presented.
    issue(8'd40, 8'd0, 1'b0, 2'd0);
    tick();
    expect_eq("t5_ld0", o_instr_valid, 4'b0001);
    tick();
    expect_eq("t5_ld1", o_instr, ld_instr(8'd40, 16'hA028 + 16'h1000));
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    expect_eq("t5_rst_valid", o_instr_valid, 4'h0);
    expect_eq("t5_rst_inflight", o_inflight, 3'd0);
    expect_eq("t5_rst_wb", o_wb_valid, 1'b0);
    issue(8'd41, 8'd0, 1'b0, 2'd0);
    expect_dispatch(0, 8'd41);

    // Finish from a processor with no outstanding command.
    i_finish = 4'b0100;
    tick();
    expect_eq("bad_fin_ack", o_finish_ack, 4'b0100);
    expect_eq("bad_fin_err", o_err, 1'b1);
    i_finish = 4'h0;
    tick();
    expect_eq("err_sticky", o_err, 1'b1);
    expect_eq("bad_fin_inflight", o_inflight, 3'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
